// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the trailing XOR checksum byte).
package boot_pkg;

    localparam int DEPTH_DEFAULT = 128;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 16;
    localparam int ADDR_W        = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CHK,
        S_DRAIN,
        S_RUN,
        S_ERR
    } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream boot loader: assembles big-endian words into program memory, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN (running XOR over count and data, checked by a final byte).
module boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              cpu_run,
    output logic              error
);

    localparam int IDX_W = $clog2(DEPTH) + 1;
    // Count comparisons need room for both a full count byte and the index.
    localparam int CNT_W = (IDX_W > BYTE_W) ? IDX_W : BYTE_W;
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t L_DONE = S_CHK;
`else
    localparam boot_state_t L_DONE = S_DRAIN;
`endif

    boot_state_t       r_state;
    boot_state_t       w_next;
    logic [BYTE_W-1:0] r_hi;
    logic [BYTE_W-1:0] r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_cnt_big;

    assign w_ready   = (r_state == S_IDLE) || (r_state == S_HI) ||
                       (r_state == S_LO)   || (r_state == S_CHK);
    assign w_accept  = in_valid && w_ready;
    assign w_last    = (CNT_W'(r_idx) + CNT_W'(1)) == CNT_W'(r_cnt);
    assign w_cnt_big = CNT_W'(in_data) > L_DEPTH;

`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] r_xor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE)
                r_xor <= in_data;
            else if ((r_state == S_HI) || (r_state == S_LO))
                r_xor <= r_xor ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_data == '0)
                        w_next = L_DONE;
                    else if (w_cnt_big)
                        w_next = S_ERR;
                    else
                        w_next = S_HI;
                end
            end
            S_HI: begin
                if (w_accept)
                    w_next = S_LO;
            end
            S_LO: begin
                if (w_accept)
                    w_next = w_last ? L_DONE : S_HI;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (w_accept)
                    w_next = (in_data == r_xor) ? S_DRAIN : S_ERR;
            end
`endif
            S_DRAIN: w_next = S_RUN;
            S_RUN:   w_next = S_RUN;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Write strobe is a single-cycle pulse; address/data hold until the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= in_data;
                        r_idx <= '0;
                    end
                    S_HI: r_hi <= in_data;
                    S_LO: begin
                        r_we   <= 1'b1;
                        r_data <= {r_hi, in_data};
                        r_addr <= ADDR_W'({r_idx, 1'b0});
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = w_ready;
    assign mem_we   = r_we;
    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign cpu_run  = (r_state == S_RUN);
    assign error    = (r_state == S_ERR);

endmodule
